// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: per-stage write enables, IF/ID flush, ID/EX bubble, halt.
// Latency: outputs are combinational from registered state and the current-cycle inputs.
// Backpressure: mem_busy freezes every stage; halt freezes permanently until rst.
module pipeline_stall_ctrl #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             halt,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, HALT} state_t;

  // Squash cycles still owed after the branch cycle itself.
  localparam logic [2:0] RELOAD = 3'(FLUSH_DEPTH - 1);

  state_t     state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       pending, pending_nxt;
  logic       stall_inc, flush_inc;

  // Decode outputs and next state; a non-zero fcnt means the pipe is still
  // squashing, which is also how MEM_WAIT knows whether it froze a FLUSH.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    pending_nxt  = pending;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (state == HALT) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      id_ex_bubble = 1'b1;
      halted       = 1'b1;
    end else if (halt) begin
      // The retiring halt cycle already freezes the PC, so it counts as a stall.
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
      state_nxt    = HALT;
    end else if (mem_busy) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      stall_inc = 1'b1;
      state_nxt = MEM_WAIT;
      // A branch resolved under a freeze is remembered and replayed on exit;
      // repeated pulses before the exit collapse into one accepted event.
      if (branch_taken && !pending) begin
        pending_nxt = 1'b1;
        flush_inc   = 1'b1;
      end
    end else if (branch_taken || pending) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_inc    = branch_taken & ~pending;
      pending_nxt  = 1'b0;
      if (FLUSH_DEPTH > 1) begin
        state_nxt = FLUSH;
        fcnt_nxt  = RELOAD;
      end else begin
        state_nxt = RUN;
        fcnt_nxt  = 3'd0;
      end
    end else if (fcnt != 3'd0) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      fcnt_nxt     = fcnt - 3'd1;
      state_nxt    = (fcnt == 3'd1) ? RUN : FLUSH;
    end else if (stall) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
      stall_inc    = 1'b1;
      state_nxt    = RUN;
    end else begin
      state_nxt = RUN;
    end
  end

  // State, squash counter, pending branch and saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fcnt      <= 3'd0;
      pending   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state   <= state_nxt;
      fcnt    <= fcnt_nxt;
      pending <= pending_nxt;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0, halt = 1'b0;

  always #5 clk = ~clk;

  logic        pc_we_a, if_id_we_a, id_ex_we_a, ex_mem_we_a, if_id_flush_a, id_ex_bubble_a, halted_a;
  logic [31:0] stall_cnt_a, flush_cnt_a;
  logic        pc_we_b, if_id_we_b, id_ex_we_b, ex_mem_we_b, if_id_flush_b, id_ex_bubble_b, halted_b;
  logic [3:0]  stall_cnt_b, flush_cnt_b;

  pipeline_stall_ctrl #(.FLUSH_DEPTH(2), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .mem_busy(mem_busy), .halt(halt),
    .pc_we(pc_we_a), .if_id_we(if_id_we_a), .id_ex_we(id_ex_we_a), .ex_mem_we(ex_mem_we_a),
    .if_id_flush(if_id_flush_a), .id_ex_bubble(id_ex_bubble_a), .halted(halted_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a));

  pipeline_stall_ctrl #(.FLUSH_DEPTH(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .mem_busy(mem_busy), .halt(halt),
    .pc_we(pc_we_b), .if_id_we(if_id_we_b), .id_ex_we(id_ex_we_b), .ex_mem_we(ex_mem_we_b),
    .if_id_flush(if_id_flush_b), .id_ex_bubble(id_ex_bubble_b), .halted(halted_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b));

  // Output vector order: {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_bubble, halted}
  logic [6:0]  out_v [2];
  logic [31:0] scnt_v [2];
  logic [31:0] fcnt_v [2];
  assign out_v[0]  = {pc_we_a, if_id_we_a, id_ex_we_a, ex_mem_we_a, if_id_flush_a, id_ex_bubble_a, halted_a};
  assign out_v[1]  = {pc_we_b, if_id_we_b, id_ex_we_b, ex_mem_we_b, if_id_flush_b, id_ex_bubble_b, halted_b};
  assign scnt_v[0] = stall_cnt_a;
  assign scnt_v[1] = 32'(stall_cnt_b);
  assign fcnt_v[0] = flush_cnt_a;
  assign fcnt_v[1] = 32'(flush_cnt_b);

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers, one slot per DUT instance.
  int     depth [2] = '{2, 3};
  longint cmax  [2] = '{64'hFFFF_FFFF, 64'd15};
  longint m_stall [2];
  longint m_flush [2];
  int     m_left  [2];
  bit     m_pend  [2];
  bit     m_halt  [2];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset(input int i);
    m_stall[i] = 0; m_flush[i] = 0; m_left[i] = 0; m_pend[i] = 0; m_halt[i] = 0;
  endtask

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // Expected outputs for this cycle, then advance the model across the edge.
  task automatic model_step(input int i, input bit s, input bit b, input bit m, input bit h,
                            output logic [6:0] e);
    if (m_halt[i]) begin
      e = 7'b0000011;
    end else if (h) begin
      e = 7'b0000010;
      m_stall[i] = sat_inc(m_stall[i], cmax[i]);
      m_halt[i] = 1;
    end else if (m) begin
      e = 7'b0000000;
      m_stall[i] = sat_inc(m_stall[i], cmax[i]);
      if (b && !m_pend[i]) begin
        m_pend[i] = 1;
        m_flush[i] = sat_inc(m_flush[i], cmax[i]);
      end
    end else if (b || m_pend[i]) begin
      e = 7'b1111110;
      if (b && !m_pend[i]) m_flush[i] = sat_inc(m_flush[i], cmax[i]);
      m_pend[i] = 0;
      m_left[i] = depth[i] - 1;
    end else if (m_left[i] > 0) begin
      e = 7'b1111110;
      m_left[i]--;
    end else if (s) begin
      e = 7'b0011010;
      m_stall[i] = sat_inc(m_stall[i], cmax[i]);
    end else begin
      e = 7'b1111000;
    end
  endtask

  // One clock: drive after the edge, compare mid-cycle, advance the model.
  task automatic cycle(input bit r, input bit s, input bit b, input bit m, input bit h);
    logic [6:0] e;
    @(posedge clk);
    #1;
    rst = r; stall = s; branch_taken = b; mem_busy = m; halt = h;
    #3;
    for (int i = 0; i < 2; i++) begin
      if (r) model_reset(i);
      chk($sformatf("dut%0d stall_cnt", i), scnt_v[i], m_stall[i]);
      chk($sformatf("dut%0d flush_cnt", i), fcnt_v[i], m_flush[i]);
      if (r) e = 7'b0000110;
      else model_step(i, s, b, m, h, e);
      chk($sformatf("dut%0d outputs", i), out_v[i], e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0);
  endtask

  initial begin
    bit mb;
    int halt_age;

    // Reset held three cycles, then released with idle inputs.
    do_reset();
    chk("reset outputs", out_v[0], 7'b0000110);
    idle(1);
    chk("post-reset outputs", out_v[0], 7'b1111000);
    chk("post-reset stall_cnt", stall_cnt_a, 0);

    // Single load-use stall.
    cycle(0, 1, 0, 0, 0);
    chk("load-use outputs", out_v[0], 7'b0011010);
    idle(1);
    chk("load-use release", out_v[0], 7'b1111000);
    chk("load-use stall_cnt", stall_cnt_a, 1);

    // Branch together with stall: two squash cycles, PC keeps advancing.
    do_reset();
    cycle(0, 1, 1, 0, 0);
    chk("branch+stall cycle1", out_v[0], 7'b1111110);
    cycle(0, 1, 0, 0, 0);
    chk("branch+stall cycle2", out_v[0], 7'b1111110);
    idle(1);
    chk("branch+stall after", out_v[0], 7'b1111000);
    chk("branch flush_cnt", flush_cnt_a, 1);
    chk("branch stall_cnt", stall_cnt_a, 0);

    // Memory wait of four cycles with a branch pulse on the second.
    do_reset();
    cycle(0, 0, 0, 1, 0);
    chk("memwait c1", out_v[0], 7'b0000000);
    cycle(0, 0, 1, 1, 0);
    chk("memwait c2", out_v[0], 7'b0000000);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("memwait c4", out_v[0], 7'b0000000);
    idle(1);
    chk("memwait exit", out_v[0], 7'b1111110);
    chk("memwait stall_cnt", stall_cnt_a, 4);
    chk("memwait flush_cnt", flush_cnt_a, 1);

    // Halt pulse, then activity that must be ignored; reset releases it.
    do_reset();
    cycle(0, 0, 0, 0, 1);
    chk("halt cycle", out_v[0], 7'b0000010);
    cycle(0, 1, 0, 0, 0);
    chk("halted stall", out_v[0], 7'b0000011);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk("halted stall_cnt", stall_cnt_a, 1);
    chk("halted flush_cnt", flush_cnt_a, 0);
    cycle(1, 0, 0, 0, 0);
    chk("halt cleared by rst", halted_a, 0);

    // Saturation of the 4-bit counter.
    do_reset();
    for (int k = 0; k < 20; k++) cycle(0, 1, 0, 0, 0);
    idle(1);
    chk("sat stall_cnt 4b", stall_cnt_b, 15);
    chk("sat stall_cnt 32b", stall_cnt_a, 20);

    // Randomized traffic with level-held mem_busy and occasional resets.
    do_reset();
    mb = 0;
    halt_age = 0;
    for (int k = 0; k < 3000; k++) begin
      bit r, s, b, h;
      if (mb) mb = ($urandom_range(0, 99) < 70);
      else    mb = ($urandom_range(0, 99) < 12);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 15);
      h = ($urandom_range(0, 299) == 0);
      r = ($urandom_range(0, 199) == 0) || (halt_age > 6);
      halt_age = m_halt[0] ? halt_age + 1 : 0;
      if (r) halt_age = 0;
      cycle(r, s, b, mb, h);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
